// File: rtl/game_pkg.sv
// Shared level encoding, FSM states and per-level lookups for the Morse number game.
package game_pkg;

    localparam logic [1:0] LVL_EASY    = 2'd0;
    localparam logic [1:0] LVL_MED     = 2'd1;
    localparam logic [1:0] LVL_HARD    = 2'd2;
    localparam logic [1:0] LVL_INVALID = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StNewRound,
        StWaitGuess,
        StFeedback,
        StDone
    } state_e;

    // x^16+x^14+x^13+x^11 in right-shifting Fibonacci form: taps on bits 0, 2, 3, 5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [6:0] level_limit(input logic [1:0] lvl,
                                               input logic [6:0] easy,
                                               input logic [6:0] med,
                                               input logic [6:0] hard);
        case (lvl)
            LVL_EASY: return easy;
            LVL_MED:  return med;
            LVL_HARD: return hard;
            default:  return 7'd0;
        endcase
    endfunction

    function automatic logic [3:0] level_points(input logic [1:0] lvl,
                                                input logic [3:0] easy,
                                                input logic [3:0] med,
                                                input logic [3:0] hard);
        case (lvl)
            LVL_EASY: return easy;
            LVL_MED:  return med;
            LVL_HARD: return hard;
            default:  return 4'd0;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

    function automatic logic [3:0] lfsr_digit(input logic [3:0] v);
        return (v >= 4'd10) ? v - 4'd10 : v;
    endfunction

endpackage

// File: rtl/bcd_score_acc.sv
// Two-digit BCD score register: add points with carry (saturating at 99),
// subtract one with borrow (floored at 00), synchronous clear.
module bcd_score_acc (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       add_i,
    input  logic [3:0] points_i,
    input  logic       sub1_i,
    output logic [3:0] ones_o,
    output logic [3:0] tens_o
);

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [4:0] ones_sum;
    logic [4:0] ones_wrap;

    always_comb begin
        ones_d    = ones_q;
        tens_d    = tens_q;
        ones_sum  = {1'b0, ones_q} + {1'b0, points_i};
        ones_wrap = ones_sum - 5'd10;
        if (clear_i) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (add_i) begin
            if (ones_sum >= 5'd10) begin
                // A carry out of the tens digit pins the score at 99
                if (tens_q == 4'd9) begin
                    ones_d = 4'd9;
                    tens_d = 4'd9;
                end else begin
                    ones_d = ones_wrap[3:0];
                    tens_d = tens_q + 4'd1;
                end
            end else begin
                ones_d = ones_sum[3:0];
            end
        end else if (sub1_i) begin
            if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else if (tens_q != 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign ones_o = ones_q;
    assign tens_o = tens_q;

endmodule

// File: rtl/gamecontrol_multi.sv
// Round controller for the Morse number game: runs ROUNDS rounds at a latched
// difficulty, drives the countdown timer and keeps a saturating BCD score.
module gamecontrol_multi
    import game_pkg::*;
#(
    parameter int unsigned ROUNDS          = 10,
    parameter int unsigned FEEDBACK_CYCLES = 50_000_000,
    parameter logic [6:0]  EASY_LIMIT      = 7'd99,
    parameter logic [6:0]  MED_LIMIT       = 7'd60,
    parameter logic [6:0]  HARD_LIMIT      = 7'd30,
    parameter logic [3:0]  EASY_PTS        = 4'd1,
    parameter logic [3:0]  MED_PTS         = 4'd2,
    parameter logic [3:0]  HARD_PTS        = 4'd3,
    parameter logic [15:0] SEED            = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] level,
    input  logic       guess_load,
    input  logic [3:0] digit,
    input  logic       timeout,
    input  logic       logout_req,
    output logic       timer_reconfig,
    output logic       timer_enable,
    output logic [6:0] timer_limit,
    output logic [3:0] number,
    output logic       number_valid,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic       correct,
    output logic [3:0] round_idx,
    output logic       game_over,
    output logic       logout_done
);

    state_e      state_q, state_d;
    logic [1:0]  level_q, level_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  number_q, number_d;
    logic [3:0]  round_q, round_d;
    logic [31:0] fb_cnt_q, fb_cnt_d;
    logic        correct_q, correct_d;
    logic        logout_q, logout_d;
    logic        sc_clear, sc_add, sc_sub1;
    logic        abort;
    logic [3:0]  round_inc;

    assign abort     = (state_q != StIdle) && (logout_req || !start);
    assign round_inc = round_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        lfsr_d    = lfsr_q;
        number_d  = number_q;
        round_d   = round_q;
        fb_cnt_d  = fb_cnt_q;
        correct_d = correct_q;
        logout_d  = 1'b0;
        sc_clear  = 1'b0;
        sc_add    = 1'b0;
        sc_sub1   = 1'b0;
        if (abort) begin
            state_d   = StIdle;
            logout_d  = 1'b1;
            sc_clear  = 1'b1;
            round_d   = 4'd0;
            number_d  = 4'd0;
            correct_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && (level != LVL_INVALID)) begin
                        level_d  = level;
                        sc_clear = 1'b1;
                        round_d  = 4'd0;
                        state_d  = StNewRound;
                    end
                end
                StNewRound: begin
                    lfsr_d    = lfsr_step(lfsr_q);
                    number_d  = lfsr_digit(lfsr_d[3:0]);
                    correct_d = 1'b0;
                    state_d   = StWaitGuess;
                end
                StWaitGuess: begin
                    // A guess in the same cycle as a timeout wins; the timeout is dropped
                    if (guess_load || timeout) begin
                        fb_cnt_d = 32'd0;
                        state_d  = StFeedback;
                        if (guess_load && (digit == number_q)) begin
                            correct_d = 1'b1;
                            sc_add    = 1'b1;
                        end else begin
                            correct_d = 1'b0;
                            sc_sub1   = (level_q == LVL_HARD);
                        end
                    end
                end
                StFeedback: begin
                    if (fb_cnt_q == FEEDBACK_CYCLES - 1) begin
                        round_d   = round_inc;
                        correct_d = 1'b0;
                        state_d   = (round_inc == 4'(ROUNDS)) ? StDone : StNewRound;
                    end else begin
                        fb_cnt_d = fb_cnt_q + 32'd1;
                    end
                end
                StDone: begin
                    if (guess_load) begin
                        state_d  = StIdle;
                        logout_d = 1'b1;
                        sc_clear = 1'b1;
                        round_d  = 4'd0;
                        number_d = 4'd0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            level_q   <= LVL_EASY;
            lfsr_q    <= SEED;
            number_q  <= 4'd0;
            round_q   <= 4'd0;
            fb_cnt_q  <= 32'd0;
            correct_q <= 1'b0;
            logout_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            lfsr_q    <= lfsr_d;
            number_q  <= number_d;
            round_q   <= round_d;
            fb_cnt_q  <= fb_cnt_d;
            correct_q <= correct_d;
            logout_q  <= logout_d;
        end
    end

    bcd_score_acc u_score (
        .clk_i    (clk),
        .rst_ni   (rst),
        .clear_i  (sc_clear),
        .add_i    (sc_add),
        .points_i (level_points(level_q, EASY_PTS, MED_PTS, HARD_PTS)),
        .sub1_i   (sc_sub1),
        .ones_o   (score_ones),
        .tens_o   (score_tens)
    );

    assign timer_reconfig = (state_q == StNewRound);
    assign timer_enable   = (state_q == StWaitGuess);
    assign number_valid   = (state_q == StWaitGuess) || (state_q == StFeedback);
    assign game_over      = (state_q == StDone);
    assign timer_limit    = (state_q == StIdle) ? 7'd0
                          : level_limit(level_q, EASY_LIMIT, MED_LIMIT, HARD_LIMIT);
    assign number         = number_q;
    assign round_idx      = round_q;
    assign correct        = correct_q;
    assign logout_done    = logout_q;

endmodule

// File: tb/tb_gamecontrol_multi.sv
// Scoreboard bench for gamecontrol_multi: random games against a behavioural model,
// with a monitor that checks every timer load, new number, round result and logout.
module tb_gamecontrol_multi;

    localparam int unsigned ROUNDS = 15;
    localparam int unsigned FB     = 4;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] level = 2'd0;
    logic       guess_load = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       timeout = 1'b0;
    logic       logout_req = 1'b0;
    logic       timer_reconfig, timer_enable, number_valid, correct, game_over, logout_done;
    logic [6:0] timer_limit;
    logic [3:0] number, score_ones, score_tens, round_idx;

    gamecontrol_multi #(
        .ROUNDS          (ROUNDS),
        .FEEDBACK_CYCLES (FB),
        .MED_PTS         (4'd7),
        .SEED            (SEED)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .level          (level),
        .guess_load     (guess_load),
        .digit          (digit),
        .timeout        (timeout),
        .logout_req     (logout_req),
        .timer_reconfig (timer_reconfig),
        .timer_enable   (timer_enable),
        .timer_limit    (timer_limit),
        .number         (number),
        .number_valid   (number_valid),
        .score_ones     (score_ones),
        .score_tens     (score_tens),
        .correct        (correct),
        .round_idx      (round_idx),
        .game_over      (game_over),
        .logout_done    (logout_done)
    );

    always #5 clk = ~clk;

    typedef enum int {EvReconf, EvRound, EvResult, EvDone, EvLogout, EvSnap} ev_e;
    typedef struct {
        ev_e kind;
        int  limit;
        int  number;
        int  correct;
        int  score;
        int  rounds;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   stim_done = 1'b0;

    // ---------------- behavioural model ----------------
    logic [15:0] lfsr_m = SEED;
    int          score_m = 0;
    int          num_m = 0;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    function automatic int limit_of(input int lvl);
        return (lvl == 0) ? 99 : (lvl == 1) ? 60 : 30;
    endfunction

    function automatic int pts_of(input int lvl);
        return (lvl == 0) ? 1 : (lvl == 1) ? 7 : 3;
    endfunction

    // 0 hit, 1 miss, 2 timeout, 3 hit+timeout, 4 logout, 5 start low, 6 reset with guess
    function automatic int pick(input int gid, input int r);
        int v;
        case (gid)
            0, 2: return 0;
            1: return (r == 0) ? 2 : 0;
            3: return (r == 0) ? 3 : 1;
            4: return (r == 2) ? 4 : 0;
            5: return (r == 1) ? 6 : 0;
            default: begin
                v = int'($urandom_range(0, 94));
                if (v < 40) return 0;
                if (v < 60) return 1;
                if (v < 75) return 2;
                if (v < 85) return 3;
                if (v < 90) return 4;
                return 5;
            end
        endcase
    endfunction

    task automatic push(input ev_e k, input int lim, input int num, input int cor,
                        input int sc, input int rnd);
        exp_t x;
        x.kind = k; x.limit = lim; x.number = num; x.correct = cor; x.score = sc; x.rounds = rnd;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_high(input bit which_go);
        int n;
        n = 0;
        while ((which_go ? game_over : timer_enable) !== 1'b1) begin
            tick();
            n++;
            if (n > 100) begin
                $display("FAIL wait_%s: got 0 after 100 cycles, required 1",
                         which_go ? "game_over" : "timer_enable");
                $fatal(1, "bench stopped: DUT stalled");
            end
        end
    endtask

    task automatic model_round(input int lvl, input int r);
        lfsr_m = lfsr_adv(lfsr_m);
        num_m  = int'(lfsr_m[3:0]) % 10;
        push(EvReconf, limit_of(lvl), 0, 0, 0, 0);
        push(EvRound, 0, num_m, 0, 0, r);
    endtask

    task automatic play_game(input int gid, input int lvl);
        int act;
        bit ended;
        level   = 2'(lvl);
        start   = 1'b1;
        score_m = 0;
        ended   = 1'b0;
        act     = 0;
        model_round(lvl, 0);
        tick();
        for (int r = 0; r < int'(ROUNDS) && !ended; r++) begin
            wait_high(1'b0);
            repeat ($urandom_range(0, 3)) tick();
            act = pick(gid, r);
            case (act)
                0, 3: begin
                    guess_load = 1'b1;
                    digit      = 4'(num_m);
                    timeout    = (act == 3);
                    score_m    = (score_m + pts_of(lvl) > 99) ? 99 : score_m + pts_of(lvl);
                    push(EvResult, 0, 0, 1, score_m, r);
                end
                1, 2: begin
                    if (act == 1) begin
                        guess_load = 1'b1;
                        digit      = 4'((num_m + int'($urandom_range(1, 9))) % 10);
                    end else begin
                        timeout = 1'b1;
                    end
                    if (lvl == 2 && score_m > 0) score_m = score_m - 1;
                    push(EvResult, 0, 0, 0, score_m, r);
                end
                4: begin logout_req = 1'b1; push(EvLogout, 0, 0, 0, 0, 0); ended = 1'b1; end
                5: begin start = 1'b0; push(EvLogout, 0, 0, 0, 0, 0); ended = 1'b1; end
                default: begin
                    rst        = 1'b0;
                    guess_load = 1'b1;
                    digit      = 4'(num_m);
                    lfsr_m     = SEED;
                    ended      = 1'b1;
                end
            endcase
            if (!ended) begin
                if (r + 1 < int'(ROUNDS)) model_round(lvl, r + 1);
                else push(EvDone, 0, 0, 0, score_m, int'(ROUNDS));
            end
            tick();
            guess_load = 1'b0;
            timeout    = 1'b0;
            logout_req = 1'b0;
            if (ended) begin
                start = 1'b0;
                if (act == 6) begin
                    rst = 1'b1;
                    push(EvSnap, 0, 0, 0, 0, 0);
                end
                tick();
            end else if ($urandom_range(0, 1) == 1) begin
                // stray press during FEEDBACK must be ignored
                guess_load = 1'b1;
                digit      = 4'($urandom_range(0, 9));
                tick();
                guess_load = 1'b0;
            end
        end
        if (!ended) begin
            wait_high(1'b1);
            repeat ($urandom_range(0, 2)) tick();
            guess_load = 1'b1;
            push(EvLogout, 0, 0, 0, 0, 0);
            tick();
            guess_load = 1'b0;
            start      = 1'b0;
            tick();
        end
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b1;
        push(EvSnap, 0, 0, 0, 0, 0);
        tick();
        level = 2'd3;
        start = 1'b1;
        repeat (4) begin
            push(EvSnap, 0, 0, 0, 0, 0);
            tick();
        end
        start = 1'b0;
        tick();
        for (int g = 0; g < 14; g++) begin
            int lv;
            case (g)
                0: lv = 0;
                1: lv = 2;
                2: lv = 1;
                3: lv = 2;
                4: lv = 1;
                5: lv = 2;
                default: lv = int'($urandom_range(0, 2));
            endcase
            play_game(g, lv);
            repeat ($urandom_range(1, 3)) tick();
        end
        repeat (5) tick();
        stim_done = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    logic        prev_te = 1'b0;
    logic        prev_go = 1'b0;
    int          cyc = 0;
    int          res_cyc = 0;
    bit          res_valid = 1'b0;
    bit          have;
    ev_e         ev;
    exp_t        e;
    logic [28:0] idle_vec;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            have = 1'b1;
            ev   = EvSnap;
            if (timer_reconfig) ev = EvReconf;
            else if (timer_enable && !prev_te) ev = EvRound;
            else if (!timer_enable && prev_te && number_valid) ev = EvResult;
            else if (game_over && !prev_go) ev = EvDone;
            else if (logout_done) ev = EvLogout;
            else if (sb.size() > 0 && sb[0].kind == EvSnap) ev = EvSnap;
            else have = 1'b0;
            if (have) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got %s, required none (t=%0t)",
                             ev.name(), $time);
                end else if (sb[0].kind != ev) begin
                    checks++;
                    errors++;
                    $display("FAIL event_order: got %s, required %s (t=%0t)",
                             ev.name(), sb[0].kind.name(), $time);
                end else begin
                    e = sb.pop_front();
                    case (ev)
                        EvReconf: begin
                            chk("timer_limit", int'(timer_limit), e.limit);
                            if (res_valid) chk("guess_to_reconfig_gap", cyc - res_cyc, int'(FB));
                            res_valid = 1'b0;
                        end
                        EvRound: begin
                            chk("number", int'(number), e.number);
                            chk("round_idx_play", int'(round_idx), e.rounds);
                        end
                        EvResult: begin
                            chk("correct", int'(correct), e.correct);
                            chk("score_result", int'(score_tens) * 10 + int'(score_ones), e.score);
                            chk("round_idx_result", int'(round_idx), e.rounds);
                            res_cyc   = cyc;
                            res_valid = 1'b1;
                        end
                        EvDone: begin
                            chk("score_done", int'(score_tens) * 10 + int'(score_ones), e.score);
                            chk("round_idx_done", int'(round_idx), e.rounds);
                            chk("number_valid_done", int'(number_valid), 0);
                            res_valid = 1'b0;
                        end
                        EvLogout: begin
                            chk("score_logout", int'(score_tens) * 10 + int'(score_ones), e.score);
                            chk("timer_enable_logout", int'(timer_enable), 0);
                            chk("game_over_logout", int'(game_over), 0);
                            chk("round_idx_logout", int'(round_idx), e.rounds);
                            res_valid = 1'b0;
                        end
                        default: begin
                            idle_vec = {timer_reconfig, timer_enable, number_valid, correct,
                                        game_over, logout_done, timer_limit, number,
                                        score_ones, score_tens, round_idx};
                            chk("idle_outputs", int'(idle_vec), 0);
                        end
                    endcase
                end
            end
        end
        prev_te = timer_enable;
        prev_go = game_over;
        if (stim_done) begin
            chk("leftover_expected", sb.size(), 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by %0t, required finish earlier", $time);
        $fatal(1, "bench stopped: watchdog");
    end

endmodule
